// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing, colour codes and the game-state encoding
// used by this block and the object renderers.
package vga_pkg;

  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_DISPLAY = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned CLK_DIV   = 2;
  localparam bit          SYNC_ACTIVE = 1'b0;

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned RGB_W   = 3;

  localparam logic [RGB_W-1:0] BLACK = 3'b000;
  localparam logic [RGB_W-1:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    GAME = 2'd1,
    WAIT = 2'd2
  } game_state_e;

endpackage

// File: rtl/vga_scan_gen_if.sv
// Scan/pixel bus between the timing generator (master) and renderers plus connector (slave).
interface vga_scan_gen_if;
  import vga_pkg::*;

  logic [RGB_W-1:0]   rgb_in;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               video_on;
  logic               pixel_tick;
  logic               frame_tick;
  logic               hsync;
  logic               vsync;
  logic [RGB_W-1:0]   rgb;

  modport master (
    input  rgb_in,
    output x, y, video_on, pixel_tick, frame_tick, hsync, vsync, rgb
  );

  modport slave (
    output rgb_in,
    input  x, y, video_on, pixel_tick, frame_tick, hsync, vsync, rgb
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with sync-window and active-area decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL      = H_TOTAL,
  parameter int unsigned DISPLAY    = H_DISPLAY,
  parameter int unsigned SYNC_START = H_DISPLAY + H_FRONT,
  parameter int unsigned SYNC_END   = H_DISPLAY + H_FRONT + H_SYNC - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COORD_W-1:0] count,
  output logic               wrap_c,
  output logic               last_nxt_c,
  output logic               sync_c,
  output logic               active_c
);

  logic [COORD_W-1:0] count_q, count_d;
  logic               at_max;

  always_comb begin
    at_max  = (count_q == COORD_W'(TOTAL - 1));
    count_d = count_q;
    if (en) begin
      count_d = at_max ? '0 : count_q + COORD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count      = count_q;
  assign wrap_c     = en && at_max;
  // Look-ahead so a registered pulse can line up with the position it marks.
  assign last_nxt_c = (count_d == COORD_W'(TOTAL - 1));
  assign sync_c     = (count_q >= COORD_W'(SYNC_START)) && (count_q <= COORD_W'(SYNC_END));
  assign active_c   = (count_q < COORD_W'(DISPLAY));

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster timing generator and registered pixel-output stage.
// Optional build macro VGA_BORDER_TEST_EN paints a white frame around the visible area.
module vga_scan_gen #(
  parameter int unsigned H_DISPLAY   = vga_pkg::H_DISPLAY,
  parameter int unsigned H_FRONT     = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC      = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK      = vga_pkg::H_BACK,
  parameter int unsigned V_DISPLAY   = vga_pkg::V_DISPLAY,
  parameter int unsigned V_FRONT     = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC      = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK      = vga_pkg::V_BACK,
  parameter int unsigned CLK_DIV     = vga_pkg::CLK_DIV,
  parameter bit          SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE
) (
  input  logic           clk,
  input  logic           reset,
  vga_scan_gen_if.master bus
);
  import vga_pkg::*;

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]   div_q, div_d;
  logic               pixel_tick_q, pixel_tick_d;
  logic               frame_tick_q, frame_tick_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;

  logic [COORD_W-1:0] h_count, v_count;
  logic               h_wrap, h_last_nxt, hs_raw, h_active;
  logic               v_wrap_unused, v_last_nxt, vs_raw, v_active;
  logic               video_on;

  vga_axis_counter #(
    .TOTAL(H_TOTAL), .DISPLAY(H_DISPLAY),
    .SYNC_START(H_DISPLAY + H_FRONT), .SYNC_END(H_DISPLAY + H_FRONT + H_SYNC - 1)
  ) u_h_axis (
    .clk(clk), .rst(reset), .en(pixel_tick_q), .count(h_count), .wrap_c(h_wrap),
    .last_nxt_c(h_last_nxt), .sync_c(hs_raw), .active_c(h_active)
  );

  vga_axis_counter #(
    .TOTAL(V_TOTAL), .DISPLAY(V_DISPLAY),
    .SYNC_START(V_DISPLAY + V_FRONT), .SYNC_END(V_DISPLAY + V_FRONT + V_SYNC - 1)
  ) u_v_axis (
    .clk(clk), .rst(reset), .en(h_wrap), .count(v_count), .wrap_c(v_wrap_unused),
    .last_nxt_c(v_last_nxt), .sync_c(vs_raw), .active_c(v_active)
  );

  assign video_on = h_active && v_active;

`ifdef VGA_BORDER_TEST_EN
  logic border;
  assign border = (h_count == '0) || (h_count == COORD_W'(H_DISPLAY - 1)) ||
                  (v_count == '0) || (v_count == COORD_W'(V_DISPLAY - 1));
`endif

  // Divider, tick generation and the pixel-late output stage.
  always_comb begin
    div_d        = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
    pixel_tick_d = (div_d == DIV_W'(CLK_DIV - 1));
    frame_tick_d = pixel_tick_d && h_last_nxt && v_last_nxt;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    rgb_d        = rgb_q;
    if (pixel_tick_q) begin
      hsync_d = hs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d = vs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      rgb_d   = video_on ? bus.rgb_in : BLACK;
`ifdef VGA_BORDER_TEST_EN
      if (video_on && border) rgb_d = WHITE;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q        <= '0;
      pixel_tick_q <= 1'b0;
      frame_tick_q <= 1'b0;
      hsync_q      <= ~SYNC_ACTIVE;
      vsync_q      <= ~SYNC_ACTIVE;
      rgb_q        <= BLACK;
    end else begin
      div_q        <= div_d;
      pixel_tick_q <= pixel_tick_d;
      frame_tick_q <= frame_tick_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      rgb_q        <= rgb_d;
    end
  end

  assign bus.x          = h_count;
  assign bus.y          = v_count;
  assign bus.video_on   = video_on;
  assign bus.pixel_tick = pixel_tick_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.hsync      = hsync_q;
  assign bus.vsync      = vsync_q;
  assign bus.rgb        = rgb_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench: full 640x480 instance for line/reset behaviour, shrunken-raster
// instance (16x12 pixels, CLK_DIV=1) for frame, vsync, vertical blanking and border.
module tb_vga_scan_gen;

`ifdef VGA_BORDER_TEST_EN
  localparam bit BORDER_ON = 1'b1;
`else
  localparam bit BORDER_ON = 1'b0;
`endif
  localparam logic [2:0] C101 = 3'b101;
  localparam logic [2:0] VIS0 = BORDER_ON ? 3'b111 : 3'b101;

  logic clk   = 1'b0;
  logic rst_b = 1'b1;
  logic rst_s = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  vga_scan_gen_if vb();
  vga_scan_gen_if sb();

  vga_scan_gen u_dut_big (.clk(clk), .reset(rst_b), .bus(vb));

  vga_scan_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .CLK_DIV(1), .SYNC_ACTIVE(1'b0)
  ) u_dut_small (.clk(clk), .reset(rst_s), .bus(sb));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart_big();
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk); @(negedge clk); rst_b = 1'b0;
  endtask

  task automatic restart_small();
    @(negedge clk); rst_s = 1'b1;
    @(negedge clk); @(negedge clk); rst_s = 1'b0;
  endtask

  task automatic test_reset();
    vb.rgb_in = 3'b101;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (vb.x !== 10'd0) begin tests_failed++; $display("FAIL rst_x: got %0d exp 0", vb.x); end
    tests_run++; if (vb.y !== 10'd0) begin tests_failed++; $display("FAIL rst_y: got %0d exp 0", vb.y); end
    tests_run++; if (vb.hsync !== 1'b1 || vb.vsync !== 1'b1) begin tests_failed++; $display("FAIL rst_sync: got hs=%b vs=%b exp 1 1", vb.hsync, vb.vsync); end
    tests_run++; if (vb.rgb !== 3'b000) begin tests_failed++; $display("FAIL rst_rgb: got %b exp 000", vb.rgb); end
    tests_run++; if (vb.pixel_tick !== 1'b0 || vb.frame_tick !== 1'b0) begin tests_failed++; $display("FAIL rst_ticks: got %b%b exp 00", vb.pixel_tick, vb.frame_tick); end
    tests_run++; if (vb.video_on !== 1'b1) begin tests_failed++; $display("FAIL rst_video_on: got %b exp 1", vb.video_on); end
  endtask

  task automatic test_release();
    @(negedge clk); rst_b = 1'b0;
    step();
    tests_run++; if (vb.pixel_tick !== 1'b1 || vb.x !== 10'd0) begin tests_failed++; $display("FAIL rel_edge1: got tick=%b x=%0d exp 1 0", vb.pixel_tick, vb.x); end
    step();
    tests_run++; if (vb.pixel_tick !== 1'b0 || vb.x !== 10'd1) begin tests_failed++; $display("FAIL rel_edge2: got tick=%b x=%0d exp 0 1", vb.pixel_tick, vb.x); end
    tests_run++; if (vb.rgb !== VIS0) begin tests_failed++; $display("FAIL rel_rgb: got %b exp %b", vb.rgb, VIS0); end
    step(); step();
    tests_run++; if (vb.x !== 10'd2) begin tests_failed++; $display("FAIL rel_edge4: got x=%0d exp 2", vb.x); end
  endtask

  task automatic test_line_blank();
    int hs_fall = -1;
    int hs_rise = -1;
    int y_wrap  = -1;
    logic [9:0] x_at_fall = '0;
    logic [9:0] x_at_wrap = '1;
    logic [9:0] x_max = '0;
    vb.rgb_in = 3'b101;
    restart_big();
    for (int n = 1; n <= 1610; n++) begin
      step();
      if (hs_fall < 0 && vb.hsync === 1'b0) begin hs_fall = n; x_at_fall = vb.x; end
      if (hs_fall >= 0 && hs_rise < 0 && vb.hsync === 1'b1) hs_rise = n;
      if (y_wrap < 0 && vb.y === 10'd1) begin y_wrap = n; x_at_wrap = vb.x; end
      if (vb.x > x_max) x_max = vb.x;
      if (n == 1280) begin tests_run++; if (vb.rgb !== VIS0) begin tests_failed++; $display("FAIL rgb_x639: got %b exp %b", vb.rgb, VIS0); end end
      if (n == 1281) begin tests_run++; if (vb.rgb !== VIS0) begin tests_failed++; $display("FAIL rgb_hold: got %b exp %b", vb.rgb, VIS0); end end
      if (n == 1282) begin tests_run++; if (vb.rgb !== 3'b000) begin tests_failed++; $display("FAIL rgb_x640_blank: got %b exp 000", vb.rgb); end end
      if (n == 1602) begin tests_run++; if (vb.rgb !== VIS0) begin tests_failed++; $display("FAIL rgb_line1_x0: got %b exp %b", vb.rgb, VIS0); end end
      if (n == 1604) begin tests_run++; if (vb.rgb !== C101) begin tests_failed++; $display("FAIL rgb_line1_x1: got %b exp 101", vb.rgb); end end
    end
    tests_run++; if (hs_fall != 1314) begin tests_failed++; $display("FAIL hs_fall_clk: got %0d exp 1314", hs_fall); end
    tests_run++; if (x_at_fall !== 10'd657) begin tests_failed++; $display("FAIL hs_fall_x: got %0d exp 657", x_at_fall); end
    tests_run++; if (hs_rise - hs_fall != 192) begin tests_failed++; $display("FAIL hs_width_clks: got %0d exp 192", hs_rise - hs_fall); end
    tests_run++; if (y_wrap != 1600 || x_at_wrap !== 10'd0) begin tests_failed++; $display("FAIL y_inc_at_wrap: got clk=%0d x=%0d exp 1600 0", y_wrap, x_at_wrap); end
    tests_run++; if (x_max !== 10'd799) begin tests_failed++; $display("FAIL x_max: got %0d exp 799", x_max); end
  endtask

  task automatic test_async_reset_big();
    vb.rgb_in = 3'b101;
    restart_big();
    for (int i = 0; i < 1000 && vb.x !== 10'd300; i++) step();
    tests_run++; if (vb.x !== 10'd300) begin tests_failed++; $display("FAIL areset_reach_x300: got %0d exp 300", vb.x); end
    #2 rst_b = 1'b1;
    #1;
    tests_run++; if (vb.x !== 10'd0 || vb.y !== 10'd0) begin tests_failed++; $display("FAIL areset_xy: got %0d,%0d exp 0,0", vb.x, vb.y); end
    tests_run++; if (vb.rgb !== 3'b000 || vb.pixel_tick !== 1'b0) begin tests_failed++; $display("FAIL areset_rgb_tick: got %b %b exp 000 0", vb.rgb, vb.pixel_tick); end
    @(negedge clk); rst_b = 1'b0;
    step(); step();
    tests_run++; if (vb.x !== 10'd1 || vb.y !== 10'd0) begin tests_failed++; $display("FAIL areset_restart: got %0d,%0d exp 1,0", vb.x, vb.y); end
  endtask

  task automatic test_frame_small();
    int vs_fall = -1;
    int vs_rise = -1;
    int ft_first = -1;
    int ft_count = 0;
    int pt_low = 0;
    sb.rgb_in = 3'b101;
    restart_small();
    for (int n = 1; n <= 400; n++) begin
      step();
      if (sb.pixel_tick !== 1'b1) pt_low++;
      if (sb.frame_tick === 1'b1) begin ft_count++; if (ft_first < 0) ft_first = n; end
      if (vs_fall < 0 && sb.vsync === 1'b0) vs_fall = n;
      if (vs_fall >= 0 && vs_rise < 0 && sb.vsync === 1'b1) vs_rise = n;
      if (n == 8)   begin tests_run++; if (sb.video_on !== 1'b1) begin tests_failed++; $display("FAIL s_video_on_x7: got %b exp 1", sb.video_on); end end
      if (n == 9)   begin tests_run++; if (sb.video_on !== 1'b0) begin tests_failed++; $display("FAIL s_video_on_x8: got %b exp 0", sb.video_on); end end
      if (n == 17)  begin tests_run++; if (sb.x !== 10'd0 || sb.y !== 10'd1) begin tests_failed++; $display("FAIL s_line_wrap: got %0d,%0d exp 0,1", sb.x, sb.y); end end
      if (n == 89)  begin tests_run++; if (sb.rgb !== VIS0) begin tests_failed++; $display("FAIL s_rgb_last_line: got %b exp %b", sb.rgb, VIS0); end end
      if (n == 90)  begin tests_run++; if (sb.rgb !== 3'b000) begin tests_failed++; $display("FAIL s_rgb_hblank: got %b exp 000", sb.rgb); end end
      if (n == 101) begin tests_run++; if (sb.rgb !== 3'b000) begin tests_failed++; $display("FAIL s_rgb_vblank: got %b exp 000", sb.rgb); end end
      if (n == 193) begin tests_run++; if (sb.x !== 10'd0 || sb.y !== 10'd0) begin tests_failed++; $display("FAIL s_frame_wrap: got %0d,%0d exp 0,0", sb.x, sb.y); end end
    end
    tests_run++; if (pt_low != 0) begin tests_failed++; $display("FAIL s_tick_const: got %0d low clks exp 0", pt_low); end
    tests_run++; if (ft_first != 192 || ft_count != 2) begin tests_failed++; $display("FAIL s_frame_tick: got first=%0d count=%0d exp 192 2", ft_first, ft_count); end
    tests_run++; if (vs_fall != 130 || vs_rise != 162) begin tests_failed++; $display("FAIL s_vsync_window: got %0d..%0d exp 130..162", vs_fall, vs_rise); end
  endtask

  task automatic test_border_small();
    logic [2:0] wb;
    wb = BORDER_ON ? 3'b111 : 3'b000;
    sb.rgb_in = 3'b000;
    restart_small();
    for (int n = 1; n <= 130; n++) begin
      step();
      if (n == 2)   begin tests_run++; if (sb.rgb !== wb) begin tests_failed++; $display("FAIL brd_x0_y0: got %b exp %b", sb.rgb, wb); end end
      if (n == 9)   begin tests_run++; if (sb.rgb !== wb) begin tests_failed++; $display("FAIL brd_xlast_y0: got %b exp %b", sb.rgb, wb); end end
      if (n == 18)  begin tests_run++; if (sb.rgb !== wb) begin tests_failed++; $display("FAIL brd_x0_y1: got %b exp %b", sb.rgb, wb); end end
      if (n == 21)  begin tests_run++; if (sb.rgb !== 3'b000) begin tests_failed++; $display("FAIL brd_inner: got %b exp 000", sb.rgb); end end
      if (n == 25)  begin tests_run++; if (sb.rgb !== wb) begin tests_failed++; $display("FAIL brd_xlast_y1: got %b exp %b", sb.rgb, wb); end end
      if (n == 42)  begin tests_run++; if (sb.rgb !== 3'b000) begin tests_failed++; $display("FAIL brd_hblank: got %b exp 000", sb.rgb); end end
      if (n == 85)  begin tests_run++; if (sb.rgb !== wb) begin tests_failed++; $display("FAIL brd_ylast: got %b exp %b", sb.rgb, wb); end end
      if (n == 114) begin tests_run++; if (sb.rgb !== 3'b000) begin tests_failed++; $display("FAIL brd_vblank: got %b exp 000", sb.rgb); end end
    end
  endtask

  task automatic test_async_reset_small();
    sb.rgb_in = 3'b101;
    restart_small();
    for (int i = 0; i < 400 && !(sb.x === 10'd12 && sb.y === 10'd8); i++) step();
    tests_run++; if (sb.hsync !== 1'b0 || sb.vsync !== 1'b0) begin tests_failed++; $display("FAIL s_areset_pre_sync: got hs=%b vs=%b exp 0 0", sb.hsync, sb.vsync); end
    #2 rst_s = 1'b1;
    #1;
    tests_run++; if (sb.hsync !== 1'b1 || sb.vsync !== 1'b1) begin tests_failed++; $display("FAIL s_areset_sync: got hs=%b vs=%b exp 1 1", sb.hsync, sb.vsync); end
    tests_run++; if (sb.x !== 10'd0 || sb.y !== 10'd0) begin tests_failed++; $display("FAIL s_areset_xy: got %0d,%0d exp 0,0", sb.x, sb.y); end
    @(negedge clk); rst_s = 1'b0;
    step(); step();
    tests_run++; if (sb.x !== 10'd1 || sb.y !== 10'd0) begin tests_failed++; $display("FAIL s_areset_restart: got %0d,%0d exp 1,0", sb.x, sb.y); end
  endtask

  initial begin
    sb.rgb_in = 3'b000;
    test_reset();
    test_release();
    test_line_blank();
    test_async_reset_big();
    test_frame_small();
    test_border_small();
    test_async_reset_small();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
